mcp3008_responder: RTL and testbench
====================================

// Module: mcp3008_responder
// PURPOSE
//  Synthesizable SPI responder that emulates an MCP3008 8-ch 10-bit ADC toward the on-board SPI master.
//  Targets the master's AD_CLK/CS/DIN/DOUT pins for hardware-in-the-loop tests without the physical ADC.
//  Channel values come from fabric registers (throttle/battery stimulus) instead of real analog inputs.
//  Oversamples the master's SPI lines in the system clock domain. Decodes start/SGL/D2..D0, returns the conversion MSB-first.
// PARAMETERS
//  SYNC_STAGES  2   flops in each input synchronizer (>=2)
//  DATA_W       10  conversion width (MCP3008 = 10)
//  NUM_CH       8   channels; D2..D0 index, fixed 8
// PORTS
//  clk          in   1           system clock, 50 MHz
//  rst          in   1           synchronous, active-high reset
//  ad_clk       in   1           SPI clock from master (asynchronous to clk)
//  cs_n         in   1           chip select, active low
//  din          in   1           master -> responder command bit
//  ch_value     in   NUM_CH*DATA_W  channel k at bits [k*DATA_W +: DATA_W]
//  dout         out  1           responder -> master data bit
//  dout_oe      out  1           1 = dout driven; top maps 0 to high-Z
//  conv_valid   out  1           1-cycle pulse when a conversion is latched
//  conv_sgl     out  1           SGL/DIFF bit of that conversion
//  conv_ch      out  3           D2..D0 of that conversion
//  conv_data    out  DATA_W      value latched for that conversion
//  frame_abort  out  1           1-cycle pulse: cs_n rose before last MSB-first bit was shifted
// BEHAVIOUR
//  Reset: state=IDLE, dout=0, dout_oe=0, conv_valid=0, conv_sgl=0, conv_ch=0, conv_data=0, frame_abort=0.
//  Reset mid-frame dominates all inputs. No output is driven until cs_n is seen high, then falls.
//  Inputs pass SYNC_STAGES flops, then one edge-detect flop. rise/fall = 1-cycle strobes.
//  Requirement: ad_clk high and low phases each >= SYNC_STAGES+2 clk.
//  DIN is sampled on ad_clk rise strobes. DOUT changes only on ad_clk fall strobes, in the same clk cycle.
//  cs_n sync high in any non-IDLE state -> IDLE next cycle, dout_oe=0, dout=0.
//  frame_abort pulses only if state was CMD, SAMPLE, NULLB or MSB.
//  FSM:
//   IDLE   : cs_n fall -> WAIT_ST; dout_oe=1, dout=0
//   WAIT_ST: rise with din=0 -> stay (leading zeros allowed); rise with din=1 -> CMD, bitcnt=0
//   CMD    : 4 rises shift din into {sgl,d2,d1,d0}. On 4th rise: latch value, pulse conv_valid next cycle -> SAMPLE
//   SAMPLE : next fall -> dout=0 (null bit) -> NULLB
//   NULLB  : next fall -> dout=data[DATA_W-1] -> MSB, bitcnt=DATA_W-1
//   MSB    : each fall decrement bitcnt, dout=data[bitcnt]; fall after bit0 -> LSB, dout=data[1]
//   LSB    : falls emit data[2]..data[DATA_W-1] (LSB-first echo, bit0 not repeated); next fall -> ZERO
//   ZERO   : dout=0 on every fall until cs_n high
//  Value latch, single-ended (sgl=1): data = ch_value[ch].
//  Value latch, pseudo-diff (sgl=0): p=ch, n=ch^1; data = (v[p]>v[n]) ? v[p]-v[n] : 0. Compare unsigned, DATA_W bits, never wraps.
//  Latched data is frozen until the next CMD completes. ch_value changes mid-frame do not affect the shifted word.
//  Coincident cs_n rise and ad_clk edge in the same cycle: cs_n wins, edge ignored.
//  Rise strobes in SAMPLE/NULLB/MSB/LSB/ZERO are ignored; din is don't-care after CMD.
// STRUCTURE
//  mcp3008_pkg: state_e enum {IDLE,WAIT_ST,CMD,SAMPLE,NULLB,MSB,LSB,ZERO}, CMD_BITS=4, MCP_CH=8.
//  Sub-module spi_edge_sync: SYNC_STAGES synchronizer + edge detect. Outputs level, rise, fall.
//   Instantiated 3x (ad_clk, cs_n, din; din uses level only).
//  Top-level holds FSM, bitcnt (4b), cmd shift reg, diff subtractor/clamp, output regs.
// TESTING
//  1 SE ch5=0x2A5, master sends 1,1,1,0,1 -> conv_valid pulse, conv_ch=5, sgl=1; dout after null = 1010100101.
//  2 Diff ch=3 (p=3,n=2), v3=0x100, v2=0x0F0 -> data 0x010. Swap to v2=0x200 -> data 0x000.
//  3 Three leading zeros before start bit, ch0=0x3FF -> normal decode, 10 ones after null bit.
//  4 Keep clocking after MSB word, ch1=0x001 -> 0000000001 then 000000000 (LSB-first echo) then zeros.
//  5 cs_n rises after 4 MSB bits -> frame_abort pulse, dout_oe=0 next cycle. Next full frame correct.
//  6 rst asserted mid-CMD, then full frame -> all outputs at reset values during rst; clean decode after.
//  All: dout changes only in cycles with a fall strobe. ch_value randomized during MSB phase does not alter output.

Source files
------------

// File: rtl/mcp3008_pkg.sv
// Shared types and constants for the MCP3008 SPI responder.
package mcp3008_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ST,
    CMD,
    SAMPLE,
    NULLB,
    MSB,
    LSB,
    ZERO
  } state_e;

  localparam int CMD_BITS = 4;
  localparam int MCP_CH   = 8;

  // States in which an early cs_n rise truncates the MSB-first word.
  function automatic logic is_abort_state(state_e s);
    return (s == CMD) || (s == SAMPLE) || (s == NULLB) || (s == MSB);
  endfunction

endpackage

// File: rtl/mcp3008_responder_if.sv
// SPI pin bundle between the on-board master and the emulated MCP3008.
interface mcp3008_responder_if;
  logic ad_clk;
  logic cs_n;
  logic din;
  logic dout;
  logic dout_oe;

  modport master (output ad_clk, cs_n, din, input dout, dout_oe);
  modport slave  (input ad_clk, cs_n, din, output dout, dout_oe);
endinterface

// File: rtl/mcp3008_responder_spi_edge_sync.sv
// Multi-flop synchronizer for one asynchronous SPI line, plus rise/fall strobes.
module spi_edge_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (rst) sync_reg[gi] <= RST_VAL;
          else     sync_reg[gi] <= async_in;
        end
      end else begin : g_next
        always_ff @(posedge clk) begin
          if (rst) sync_reg[gi] <= RST_VAL;
          else     sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) prev_reg <= RST_VAL;
    else     prev_reg <= sync_reg[SYNC_STAGES-1];
  end

  assign level = sync_reg[SYNC_STAGES-1];
  assign rise  = level & ~prev_reg;
  assign fall  = ~level & prev_reg;

endmodule

// File: rtl/mcp3008_responder.sv
// MCP3008 emulator: decodes the start/SGL/D2..D0 command and shifts the
// selected (or pseudo-differential) fabric channel value back MSB-first.
module mcp3008_responder
  import mcp3008_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 10,
  parameter int NUM_CH      = MCP_CH
) (
  input  logic                     clk,
  input  logic                     rst,
  mcp3008_responder_if.slave       spi,
  input  logic [NUM_CH*DATA_W-1:0] ch_value,
  output logic                     conv_valid,
  output logic                     conv_sgl,
  output logic [2:0]               conv_ch,
  output logic [DATA_W-1:0]        conv_data,
  output logic                     frame_abort
);

  logic ad_level, ad_rise, ad_fall;
  logic cs_level, cs_fall;
  logic din_level;

  // cs_n chain resets low so a master already holding cs_n low is never
  // mistaken for a fresh falling edge; it must be seen high first.
  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_ad_sync (
    .clk(clk), .rst(rst), .async_in(spi.ad_clk),
    .level(ad_level), .rise(ad_rise), .fall(ad_fall)
  );
  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_cs_sync (
    .clk(clk), .rst(rst), .async_in(spi.cs_n),
    .level(cs_level), .rise(), .fall(cs_fall)
  );
  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_din_sync (
    .clk(clk), .rst(rst), .async_in(spi.din),
    .level(din_level), .rise(), .fall()
  );

  state_e                  state_reg;
  logic [3:0]              bitcnt_reg;
  logic [CMD_BITS-2:0]     cmd_reg;
  logic                    dout_reg;
  logic                    dout_oe_reg;
  logic                    conv_valid_reg;
  logic                    conv_sgl_reg;
  logic [2:0]              conv_ch_reg;
  logic [DATA_W-1:0]       conv_data_reg;
  logic                    frame_abort_reg;

  logic [DATA_W-1:0]       ch_arr [NUM_CH];
  logic [CMD_BITS-1:0]     cmd_next;
  logic [2:0]              ch_p;
  logic [2:0]              ch_n;
  logic [DATA_W-1:0]       v_p;
  logic [DATA_W-1:0]       v_n;
  logic [DATA_W-1:0]       latch_val;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign ch_arr[gi] = ch_value[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Value computed from the command as it completes on the 4th rise.
  always_comb begin
    cmd_next  = {cmd_reg, din_level};
    ch_p      = cmd_next[2:0];
    ch_n      = cmd_next[2:0] ^ 3'd1;
    v_p       = ch_arr[ch_p];
    v_n       = ch_arr[ch_n];
    latch_val = '0;
    if (cmd_next[3])     latch_val = v_p;
    else if (v_p > v_n)  latch_val = v_p - v_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      bitcnt_reg      <= '0;
      cmd_reg         <= '0;
      dout_reg        <= 1'b0;
      dout_oe_reg     <= 1'b0;
      conv_valid_reg  <= 1'b0;
      conv_sgl_reg    <= 1'b0;
      conv_ch_reg     <= '0;
      conv_data_reg   <= '0;
      frame_abort_reg <= 1'b0;
    end else begin
      conv_valid_reg  <= 1'b0;
      frame_abort_reg <= 1'b0;
      // Deselect overrides any clock edge arriving in the same cycle.
      if (state_reg != IDLE && cs_level) begin
        state_reg       <= IDLE;
        dout_reg        <= 1'b0;
        dout_oe_reg     <= 1'b0;
        frame_abort_reg <= is_abort_state(state_reg);
      end else begin
        case (state_reg)
          IDLE: begin
            if (cs_fall) begin
              state_reg   <= WAIT_ST;
              dout_oe_reg <= 1'b1;
              dout_reg    <= 1'b0;
            end
          end
          WAIT_ST: begin
            if (ad_rise && din_level) begin
              state_reg  <= CMD;
              bitcnt_reg <= '0;
            end
          end
          CMD: begin
            if (ad_rise) begin
              cmd_reg    <= cmd_next[CMD_BITS-2:0];
              bitcnt_reg <= bitcnt_reg + 4'd1;
              if (bitcnt_reg == 4'(CMD_BITS - 1)) begin
                conv_valid_reg <= 1'b1;
                conv_sgl_reg   <= cmd_next[3];
                conv_ch_reg    <= cmd_next[2:0];
                conv_data_reg  <= latch_val;
                state_reg      <= SAMPLE;
              end
            end
          end
          SAMPLE: begin
            if (ad_fall) begin
              dout_reg  <= 1'b0;
              state_reg <= NULLB;
            end
          end
          NULLB: begin
            if (ad_fall) begin
              dout_reg   <= conv_data_reg[DATA_W-1];
              bitcnt_reg <= 4'(DATA_W - 1);
              state_reg  <= MSB;
            end
          end
          MSB: begin
            if (ad_fall) begin
              if (bitcnt_reg == 4'd0) begin
                dout_reg   <= conv_data_reg[1];
                bitcnt_reg <= 4'd1;
                state_reg  <= LSB;
              end else begin
                dout_reg   <= conv_data_reg[bitcnt_reg - 4'd1];
                bitcnt_reg <= bitcnt_reg - 4'd1;
              end
            end
          end
          LSB: begin
            if (ad_fall) begin
              if (bitcnt_reg == 4'(DATA_W - 1)) begin
                dout_reg  <= 1'b0;
                state_reg <= ZERO;
              end else begin
                dout_reg   <= conv_data_reg[bitcnt_reg + 4'd1];
                bitcnt_reg <= bitcnt_reg + 4'd1;
              end
            end
          end
          ZERO: begin
            if (ad_fall) dout_reg <= 1'b0;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign spi.dout    = dout_reg;
  assign spi.dout_oe = dout_oe_reg;
  assign conv_valid  = conv_valid_reg;
  assign conv_sgl    = conv_sgl_reg;
  assign conv_ch     = conv_ch_reg;
  assign conv_data   = conv_data_reg;
  assign frame_abort = frame_abort_reg;

  // ad_level is only consumed through its strobes.
  logic unused_ok;
  assign unused_ok = ad_level;

endmodule

// File: tb/tb_mcp3008_responder.sv
// Scoreboard bench: a bit-banging SPI master with a behavioural MCP3008 model.
module tb_mcp3008_responder;

  localparam int DATA_W = 10;
  localparam int NUM_CH = 8;
  localparam int HALF   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mcp3008_responder_if spi ();

  logic [NUM_CH*DATA_W-1:0] ch_value;
  logic                     conv_valid;
  logic                     conv_sgl;
  logic [2:0]               conv_ch;
  logic [DATA_W-1:0]        conv_data;
  logic                     frame_abort;

  mcp3008_responder #(.SYNC_STAGES(2), .DATA_W(DATA_W), .NUM_CH(NUM_CH)) dut (
    .clk(clk), .rst(rst), .spi(spi), .ch_value(ch_value),
    .conv_valid(conv_valid), .conv_sgl(conv_sgl), .conv_ch(conv_ch),
    .conv_data(conv_data), .frame_abort(frame_abort)
  );

  typedef struct {
    logic              sgl;
    logic [2:0]        ch;
    logic [DATA_W-1:0] data;
  } conv_t;

  conv_t conv_q[$];
  logic  bit_q[$];
  int    checks = 0;
  int    failures = 0;
  int    exp_aborts = 0;
  int    got_aborts = 0;
  logic  prev_dout = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: single-ended picks the channel; pseudo-diff clamps at zero.
  function automatic logic [DATA_W-1:0] model(input logic [NUM_CH*DATA_W-1:0] cv,
                                              input logic sgl, input logic [2:0] ch);
    int p, n;
    p = int'(cv[int'(ch)*DATA_W +: DATA_W]);
    n = int'(cv[(int'(ch) ^ 1)*DATA_W +: DATA_W]);
    if (sgl) return DATA_W'(p);
    return (p > n) ? DATA_W'(p - n) : '0;
  endfunction

  // Value on dout seen by the master at word position j (0 = null bit).
  function automatic logic exp_bit(input int j, input logic [DATA_W-1:0] d);
    if (j <= 0) return 1'b0;
    if (j <= DATA_W) return d[DATA_W - j];
    if (j <= 2*DATA_W - 1) return d[j - DATA_W];
    return 1'b0;
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dout"}, spi.dout, 0);
    check({tag, "_dout_oe"}, spi.dout_oe, 0);
    check({tag, "_conv_valid"}, conv_valid, 0);
    check({tag, "_conv_sgl"}, conv_sgl, 0);
    check({tag, "_conv_ch"}, conv_ch, 0);
    check({tag, "_conv_data"}, conv_data, 0);
    check({tag, "_frame_abort"}, frame_abort, 0);
  endtask

  task automatic run_frame(input int lead, input logic sgl, input logic [2:0] ch,
                           input int nrises, input bit scramble);
    logic [DATA_W-1:0] d;
    logic [3:0]        cmd4;
    logic              b;
    conv_t             c;
    int                falls_after;
    cmd4 = {sgl, ch};
    d = model(ch_value, sgl, ch);
    if (nrises >= lead + 5) begin
      c.sgl = sgl; c.ch = ch; c.data = d;
      conv_q.push_back(c);
    end
    for (int r = 0; r < nrises; r++) bit_q.push_back(exp_bit(r - (lead + 5), d));
    falls_after = nrises - lead - 4;
    if (nrises > lead && falls_after <= DATA_W + 1) exp_aborts++;
    $display("frame lead=%0d sgl=%0d ch=%0d rises=%0d exp_data=%03h", lead, sgl, ch, nrises, d);

    spi.cs_n = 1'b0;
    wait_clks(HALF);
    for (int r = 0; r < nrises; r++) begin
      if (r < lead)          b = 1'b0;
      else if (r == lead)    b = 1'b1;
      else if (r <= lead+4)  b = cmd4[3 - (r - lead - 1)];
      else                   b = 1'($urandom);
      spi.din = b;
      if (scramble && r >= lead + 7) ch_value = {$urandom, $urandom, $urandom};
      wait_clks(HALF);
      spi.ad_clk = 1'b1;
      wait_clks(HALF);
      spi.ad_clk = 1'b0;
    end
    wait_clks(HALF);
    spi.cs_n = 1'b1;
    wait_clks(HALF);
    check("oe_after_cs_high", spi.dout_oe, 0);
    check("dout_after_cs_high", spi.dout, 0);
  endtask

  // Bit monitor: master reads dout on every ad_clk rise while selected.
  always @(posedge spi.ad_clk) begin
    if (!spi.cs_n && !rst) begin
      if (bit_q.size() == 0) begin
        check("unexpected_rise", 1, 0);
      end else begin
        check("dout_bit", spi.dout, bit_q.pop_front());
        check("dout_oe_in_frame", spi.dout_oe, 1);
      end
    end
  end

  // Conversion monitor.
  always @(negedge clk) begin
    conv_t e;
    if (conv_valid) begin
      if (conv_q.size() == 0) begin
        check("unexpected_conv", 1, 0);
      end else begin
        e = conv_q.pop_front();
        $display("conv sgl=%0d ch=%0d data=%03h (exp %0d %0d %03h)",
                 conv_sgl, conv_ch, conv_data, e.sgl, e.ch, e.data);
        check("conv_sgl", conv_sgl, e.sgl);
        check("conv_ch", conv_ch, e.ch);
        check("conv_data", conv_data, e.data);
      end
    end
    if (frame_abort) got_aborts++;
    // dout may only move while ad_clk is low (after a fall), on deselect, or in reset.
    if (spi.dout !== prev_dout)
      check("dout_change_on_fall", (spi.ad_clk == 1'b0) || spi.cs_n || rst, 1);
    prev_dout = spi.dout;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lead, nr;
    spi.ad_clk = 1'b0;
    spi.cs_n   = 1'b1;
    spi.din    = 1'b0;
    ch_value   = {$urandom, $urandom, $urandom};
    wait_clks(5);
    check_reset_outputs("reset");
    rst = 1'b0;
    wait_clks(10);

    // Single-ended ch5.
    ch_value[5*DATA_W +: DATA_W] = 10'h2A5;
    run_frame(0, 1'b1, 3'd5, 5 + 21, 1'b0);

    // Pseudo-differential ch3 vs ch2, then clamped to zero.
    ch_value[3*DATA_W +: DATA_W] = 10'h100;
    ch_value[2*DATA_W +: DATA_W] = 10'h0F0;
    run_frame(0, 1'b0, 3'd3, 5 + 12, 1'b0);
    ch_value[2*DATA_W +: DATA_W] = 10'h200;
    run_frame(0, 1'b0, 3'd3, 5 + 12, 1'b0);

    // Leading zeros before the start bit.
    ch_value[0 +: DATA_W] = 10'h3FF;
    run_frame(3, 1'b1, 3'd0, 3 + 5 + 12, 1'b0);

    // Keep clocking past the word: LSB-first echo then zeros.
    ch_value[1*DATA_W +: DATA_W] = 10'h001;
    run_frame(0, 1'b1, 3'd1, 5 + 26, 1'b0);

    // Early deselect after four MSB bits, then a clean frame.
    run_frame(0, 1'b1, 3'd6, 5 + 5, 1'b0);
    run_frame(1, 1'b1, 3'd6, 1 + 5 + 21, 1'b1);

    // Reset asserted mid-command.
    bit_q.push_back(1'b0); bit_q.push_back(1'b0); bit_q.push_back(1'b0);
    spi.cs_n = 1'b0;
    wait_clks(HALF);
    for (int r = 0; r < 3; r++) begin
      spi.din = (r == 1) ? 1'b0 : 1'b1;
      wait_clks(HALF);
      spi.ad_clk = 1'b1;
      wait_clks(HALF);
      if (r < 2) spi.ad_clk = 1'b0;
    end
    rst = 1'b1;
    wait_clks(3);
    check_reset_outputs("midrst");
    spi.ad_clk = 1'b0;
    spi.cs_n   = 1'b1;
    wait_clks(4);
    check_reset_outputs("midrst_hold");
    rst = 1'b0;
    wait_clks(10);
    run_frame(0, 1'b0, 3'd4, 5 + 21, 1'b0);

    // Randomized frames, some truncated, with ch_value churn during the word.
    for (int k = 0; k < 24; k++) begin
      lead = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) nr = lead + $urandom_range(1, 25);
      else                           nr = lead + 5 + $urandom_range(12, 28);
      run_frame(lead, 1'($urandom), 3'($urandom), nr, 1'($urandom));
      wait_clks($urandom_range(2, 6));
    end

    wait_clks(20);
    check("conv_queue_empty", conv_q.size(), 0);
    check("bit_queue_empty", bit_q.size(), 0);
    check("abort_count", got_aborts, exp_aborts);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
